div128by64: RTL

Sequential unsigned divider: a 128-bit dividend by a 64-bit divisor gives a 64-bit quotient and a 64-bit remainder. It is the inverse datapath of the 64x64 multiplier: feeding it the multiplier's 128-bit product and one operand recovers the other operand with remainder zero. It uses radix-2 restoring division and resolves a configurable number of quotient bits per clock. Operands enter and results leave through valid/ready handshakes.

---
 rtl/div128by64_pkg.sv | 20 ++
 rtl/div128by64_step.sv | 31 +++
 rtl/div128by64.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div128by64_pkg.sv
// div_pkg: shared widths, FSM state type and the step-count helper for the
// 128-by-64 restoring divider.
package div_pkg;

  localparam int DIVIDEND_W = 128;
  localparam int DIVISOR_W  = 64;
  localparam int QUOT_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of clocks needed to resolve all 64 quotient bits.
  function automatic int step_count(input int steps_per_cycle);
    return 64 / steps_per_cycle;
  endfunction

endpackage

// File: rtl/div128by64_step.sv
// div_step: one purely combinational radix-2 restoring division step.
// Ports:
//   i_r      65-bit partial remainder entering the step
//   i_d      64-bit divisor
//   i_q_msb  bit shifted out of the dividend/quotient register
//   o_r      65-bit partial remainder leaving the step
//   o_q_bit  resolved quotient bit
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   i_r,
  input  logic [DIVISOR_W-1:0] i_d,
  input  logic                 i_q_msb,
  output logic [DIVISOR_W:0]   o_r,
  output logic                 o_q_bit
);

  logic [DIVISOR_W:0] w_shift;
  logic [DIVISOR_W:0] w_diff;
  logic               w_ge;
  // The remainder msb is always 0 between steps, so it is shifted out unused.
  logic               w_unused_msb;

  assign w_unused_msb = i_r[DIVISOR_W];
  assign w_shift      = {i_r[DIVISOR_W-1:0], i_q_msb};
  assign w_ge         = (w_shift >= {1'b0, i_d});
  assign w_diff       = w_shift - {1'b0, i_d};
  assign o_r          = w_ge ? w_diff : w_shift;
  assign o_q_bit      = w_ge;

endmodule

// File: rtl/div128by64.sv
// div128by64: sequential unsigned 128/64 restoring divider with valid/ready
// handshakes on both sides.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (in_ready high only in IDLE)
//   dividend, divisor        128-bit numerator, 64-bit denominator
//   out_valid/out_ready      result handshake (held until accepted)
//   quotient, remainder      64-bit results
//   div_by_zero, overflow    exception flags
module div128by64
  import div_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int         STEP_COUNT = step_count(STEPS_PER_CYCLE);
  // The first group of steps is resolved on the accept edge itself, so RUN
  // only needs STEP_COUNT-1 further clocks.
  localparam logic [6:0] LAST_CNT   = 7'(STEP_COUNT - 2);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : g_bad_param
    $error("div128by64: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  div_state_t           r_state;
  logic [6:0]           r_cnt;
  logic [DIVISOR_W:0]   r_r;
  logic [QUOT_W-1:0]    r_q;
  logic [DIVISOR_W-1:0] r_d;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [QUOT_W-1:0]    r_quotient;
  logic [DIVISOR_W-1:0] r_remainder;
  logic                 r_div_by_zero;
  logic                 r_overflow;

  logic [DIVISOR_W:0]   w_r0;
  logic [QUOT_W-1:0]    w_q0;
  logic [DIVISOR_W-1:0] w_d;
  logic [DIVISOR_W:0]   w_r_last;
  logic [QUOT_W-1:0]    w_q_last;

  // In IDLE the chain works on the incoming operands so the accept edge
  // already resolves the first group of quotient bits.
  always_comb begin
    w_r0 = {1'b0, r_r[DIVISOR_W-1:0]};
    w_q0 = r_q;
    w_d  = r_d;
    if (r_state == RUN) begin
      w_r0 = r_r;
      w_q0 = r_q;
      w_d  = r_d;
    end else begin
      w_r0 = {1'b0, dividend[DIVIDEND_W-1:QUOT_W]};
      w_q0 = dividend[QUOT_W-1:0];
      w_d  = divisor;
    end
  end

  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
    logic [DIVISOR_W:0] w_r_in;
    logic [QUOT_W-1:0]  w_q_in;
    logic [DIVISOR_W:0] w_r_out;
    logic [QUOT_W-1:0]  w_q_out;
    logic               w_q_bit;

    if (k == 0) begin : g_first
      assign w_r_in = w_r0;
      assign w_q_in = w_q0;
    end else begin : g_next
      assign w_r_in = g_step[k-1].w_r_out;
      assign w_q_in = g_step[k-1].w_q_out;
    end

    div_step u_step (
      .i_r     (w_r_in),
      .i_d     (w_d),
      .i_q_msb (w_q_in[QUOT_W-1]),
      .o_r     (w_r_out),
      .o_q_bit (w_q_bit)
    );

    assign w_q_out = {w_q_in[QUOT_W-2:0], w_q_bit};
  end

  assign w_r_last = g_step[STEPS_PER_CYCLE-1].w_r_out;
  assign w_q_last = g_step[STEPS_PER_CYCLE-1].w_q_out;

  // Control FSM, step counter, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 7'd0;
      r_r           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_cnt      <= 7'd0;
            if (divisor == 64'd0) begin
              r_quotient    <= '1;
              r_remainder   <= dividend[QUOT_W-1:0];
              r_div_by_zero <= 1'b1;
              r_overflow    <= 1'b0;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end else if (dividend[DIVIDEND_W-1:QUOT_W] >= divisor) begin
              r_quotient    <= '1;
              r_remainder   <= '0;
              r_div_by_zero <= 1'b0;
              r_overflow    <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_d     <= divisor;
              r_r     <= w_r_last;
              r_q     <= w_q_last;
              r_state <= RUN;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          r_r <= w_r_last;
          r_q <= w_q_last;
          if (r_cnt == LAST_CNT) begin
            r_quotient    <= w_q_last;
            r_remainder   <= w_r_last[DIVISOR_W-1:0];
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
